// File: rtl/cpu_defs.sv
// Shared CPU definitions: datapath width, ALU opcodes and the divider state encoding.
package cpu_defs;

    localparam int DATA_W = 32;

    localparam logic [4:0] ADD            = 5'b00011;
    localparam logic [4:0] SUB            = 5'b00100;
    localparam logic [4:0] MULTIPLICATION = 5'b01110;
    localparam logic [4:0] DIVISION       = 5'b01111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {A,Q} left, subtract D if it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   a,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH:0]   a_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH:0]   diff;
    logic             fits;

    // shifted carries one extra bit so the compare never wraps
    assign shifted = {a, q[WIDTH-1]};
    assign fits    = shifted >= {2'b00, d};
    assign diff    = shifted[WIDTH:0] - {1'b0, d};

    assign a_next = fits ? diff : shifted[WIDTH:0];
    assign q_next = {q[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_div_32.sv
// Multi-cycle signed restoring divider producing {remainder, quotient} for the ALU div_out bus.
import cpu_defs::*;

module seq_div_32 #(
    parameter int WIDTH = DATA_W
) (
    input  logic               clk,
    input  logic               clear,
    input  logic               start,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic [2*WIDTH-1:0] div_out,
    output div_state_e         state
);

    localparam int CNT_W = $clog2(WIDTH);

    // Handshake: start is sampled only while state==IDLE; the accepting edge latches
    // the operands. done pulses one cycle when div_out/div_by_zero are updated.

    div_state_e       next_state;
    logic             accept;
    logic [WIDTH:0]   a_reg;
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] d_reg;
    logic [CNT_W-1:0] count;
    logic             sign_q;
    logic             sign_r;
    logic             dz;

    logic [WIDTH:0]   a_step;
    logic [WIDTH-1:0] q_step;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign dvd_mag = dividend[WIDTH-1] ? -dividend : dividend;
    assign dvs_mag = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign busy    = (state == RUN) || (state == FIX);

    div_step #(.WIDTH(WIDTH)) u_step (
        .a      (a_reg),
        .q      (q_reg),
        .d      (d_reg),
        .a_next (a_step),
        .q_next (q_step)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (divisor == '0) ? FIX : RUN;
                end
            end
            RUN: begin
                if (count == CNT_W'(WIDTH - 1)) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // On divide-by-zero Q still holds |dividend|, so re-applying the sign restores it
    always_comb begin
        quo_fix = sign_q ? -q_reg : q_reg;
        rem_fix = sign_r ? -a_reg[WIDTH-1:0] : a_reg[WIDTH-1:0];
        if (dz) begin
            quo_fix = '1;
            rem_fix = sign_r ? -q_reg : q_reg;
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            a_reg       <= '0;
            q_reg       <= '0;
            d_reg       <= '0;
            count       <= '0;
            sign_q      <= 1'b0;
            sign_r      <= 1'b0;
            dz          <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            div_out     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_reg       <= '0;
                        q_reg       <= dvd_mag;
                        d_reg       <= dvs_mag;
                        count       <= '0;
                        sign_q      <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        sign_r      <= dividend[WIDTH-1];
                        dz          <= (divisor == '0);
                        div_by_zero <= 1'b0;
                    end
                end
                RUN: begin
                    a_reg <= a_step;
                    q_reg <= q_step;
                    count <= count + 1'b1;
                end
                FIX: begin
                    done        <= 1'b1;
                    div_out     <= {rem_fix, quo_fix};
                    div_by_zero <= dz;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_32.sv
// Randomized scoreboard bench for seq_div_32 against a plain-arithmetic division model.
module tb_seq_div_32;
    import cpu_defs::*;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             clear;
    logic             start;
    logic [W-1:0]     dividend;
    logic [W-1:0]     divisor;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [2*W-1:0]   div_out;
    div_state_e       state;

    logic [2*W:0]     exp_q[$];
    int               lat_q[$];
    int               cyc = 0;
    int               checks = 0;
    int               passed = 0;

    seq_div_32 dut (
        .clk         (clk),
        .clear       (clear),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .div_out     (div_out),
        .state       (state)
    );

    // clock/reset block
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // reference: {dz, remainder, quotient}; 64-bit signed arithmetic truncates toward zero
    function automatic logic [2*W:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, qq, rr;
        if (b == '0) return {1'b1, a, {W{1'b1}}};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        qq = sa / sb;
        rr = sa % sb;
        return {1'b0, rr[W-1:0], qq[W-1:0]};
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // driver tasks
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            $display("FAIL issue_timeout: busy=%b expected 0", busy);
            return;
        end
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(ref_div(a, b));
        lat_q.push_back(cyc + ((b == '0) ? 1 : W + 1));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain_timeout: pending=%0d expected 0", exp_q.size());
            exp_q.delete();
            lat_q.delete();
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [2*W:0] e;
        int           l;
        if (!clear && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_done: div_out=%h with nothing pending", div_out);
            end else begin
                e = exp_q.pop_front();
                l = lat_q.pop_front();
                check("div_out", div_out, e[2*W-1:0]);
                check("div_by_zero", 64'(div_by_zero), 64'(e[2*W]));
                check("latency", 64'(cyc), 64'(l));
            end
        end
    end

    initial begin
        logic [W-1:0] ra, rb;
        int           n;

        clear = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor  = '0;
        #12;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_dz", 64'(div_by_zero), 64'(0));
        check("rst_div_out", div_out, 64'(0));
        check("rst_state", 64'(state), 64'(IDLE));
        @(negedge clk);
        clear = 1'b0;

        // directed cases
        issue(32'd100, 32'd7);
        drain();
        issue(-32'sd100, 32'd7);
        issue(32'd100, -32'sd7);
        issue(32'd5, 32'd0);
        issue(32'd9, 32'd3);
        issue(32'h8000_0000, 32'hFFFF_FFFF);
        issue(32'd7, 32'd100);
        issue(32'd0, 32'd5);
        issue(-32'sd7, 32'd0);
        issue(32'h8000_0000, 32'd1);
        issue(32'h7FFF_FFFF, 32'h8000_0000);
        drain();

        // start re-pulsed mid-run is ignored
        issue(32'd100, 32'd7);
        check("busy_run", 64'(busy), 64'(1));
        repeat (9) @(posedge clk);
        #1;
        dividend = 32'd999;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // start held high through the done cycle is accepted there
        issue(32'd1000, -32'sd3);
        dividend = -32'sd50;
        divisor  = 32'd6;
        start    = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(ref_div(-32'sd50, 32'd6));
        lat_q.push_back(cyc + W + 1);
        drain();

        // asynchronous clear mid-run aborts with no done
        issue(32'd123456, -32'sd789);
        repeat (15) @(posedge clk);
        #3;
        clear = 1'b1;
        #1;
        check("clr_busy", 64'(busy), 64'(0));
        check("clr_done", 64'(done), 64'(0));
        check("clr_div_out", div_out, 64'(0));
        check("clr_dz", 64'(div_by_zero), 64'(0));
        exp_q.delete();
        lat_q.delete();
        @(negedge clk);
        clear = 1'b0;
        repeat (40) @(negedge clk);
        issue(-32'sd123456, 32'd789);
        drain();

        // randomized operands, biased toward zero and small divisors
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = '0;
                1:       rb = W'($urandom_range(1, 20));
                2:       rb = -W'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
            issue(ra, rb);
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
